// File: rtl/baser_pkg.sv
// Shared 64b/66b -> 256b/257b definitions: sync headers, widths and type-field geometry.
package baser_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int unsigned SH_W         = 2;
    localparam int unsigned BLK_PER_TC   = 4;
    localparam int unsigned CNT_W        = 32;
    // Upper nibble of the 8-bit control block type field sits at payload[7:4]
    localparam int unsigned TYPE_NIB_LSB = 4;
    localparam int unsigned TYPE_NIB_W   = 4;

    // Transcoded word width for a given 66b payload width
    function automatic int unsigned tc_width(input int unsigned dw);
        return BLK_PER_TC * dw + 1;
    endfunction

    localparam int unsigned TC_W_257 = tc_width(64);

    // A header is legal only if it marks a data or a control block
    function automatic logic hdr_legal(input logic [1:0] h);
        return (h == SH_DATA) || (h == SH_CTRL);
    endfunction

endpackage

// File: rtl/baser_257b_compress.sv
// Combinational 4x66b -> 257b transcoder: all-data pass-through or flagged
// control form with the first non-data block's upper type nibble dropped.
module baser_257b_compress
    import baser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TC_WIDTH   = tc_width(DATA_WIDTH)
) (
    input  logic [BLK_PER_TC*DATA_WIDTH-1:0] payloads,
    input  logic [BLK_PER_TC*SH_W-1:0]       headers,
    output logic [TC_WIDTH-1:0]              tc_coded_c,
    output logic                             tc_err_c
);

    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned COMP_W = BLK_PER_TC * DW - TYPE_NIB_W;
    localparam int unsigned NIB_HI = TYPE_NIB_LSB + TYPE_NIB_W;

    logic [DW-1:0]         p [BLK_PER_TC];
    logic [BLK_PER_TC-1:0] data_flags;
    logic [1:0]            first_nd;
    logic                  found;
    logic [COMP_W-1:0]     comp;

    // Classify blocks, locate the first non-data block and build the output word
    always_comb begin
        data_flags = '0;
        first_nd   = 2'd0;
        found      = 1'b0;
        tc_err_c   = 1'b0;
        comp       = '0;
        tc_coded_c = '0;
        for (int i = 0; i < int'(BLK_PER_TC); i++) begin
            p[i]          = payloads[i*DW +: DW];
            data_flags[i] = (headers[i*SH_W +: SH_W] == SH_DATA);
            if (!hdr_legal(headers[i*SH_W +: SH_W])) begin
                tc_err_c = 1'b1;
            end
            if (!found && !data_flags[i]) begin
                first_nd = 2'(i);
                found    = 1'b1;
            end
        end
        case (first_nd)
            2'd0:    comp = {p[3], p[2], p[1], p[0][DW-1:NIB_HI], p[0][TYPE_NIB_LSB-1:0]};
            2'd1:    comp = {p[3], p[2], p[1][DW-1:NIB_HI], p[1][TYPE_NIB_LSB-1:0], p[0]};
            2'd2:    comp = {p[3], p[2][DW-1:NIB_HI], p[2][TYPE_NIB_LSB-1:0], p[1], p[0]};
            default: comp = {p[3][DW-1:NIB_HI], p[3][TYPE_NIB_LSB-1:0], p[2], p[1], p[0]};
        endcase
        if (&data_flags) begin
            tc_coded_c = {payloads, 1'b1};
        end else begin
            tc_coded_c = {comp, data_flags, 1'b0};
        end
    end

endmodule

// File: rtl/baser_257b_generator.sv
// Gathers four 66b blocks and emits one registered 257b transcoded word.
// Optional statistics counters: define BASER_257B_GEN_STATS_EN.
module baser_257b_generator
    import baser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TC_WIDTH   = tc_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH+1:0] i_block,
    input  logic                  i_restart,
    output logic                  o_valid,
    output logic [TC_WIDTH-1:0]   o_tc_coded,
    output logic                  o_tc_err,
    output logic [CNT_W-1:0]      o_block_count,
    output logic [CNT_W-1:0]      o_data_count,
    output logic [CNT_W-1:0]      o_ctrl_count,
    output logic [CNT_W-1:0]      o_inv_block_count
);

    localparam int unsigned NSTORE = BLK_PER_TC - 1;

    logic [1:0]                          slot_q;
    logic [DATA_WIDTH-1:0]               pay_q [NSTORE];
    logic [SH_W-1:0]                     hdr_q [NSTORE];
    logic                                accept_c;
    logic                                last_c;
    logic [BLK_PER_TC*DATA_WIDTH-1:0]    payloads_c;
    logic [BLK_PER_TC*SH_W-1:0]          headers_c;
    logic [TC_WIDTH-1:0]                 tc_c;
    logic                                err_c;

    // Accept qualification; the fourth block goes straight from the input to the compressor
    always_comb begin
        accept_c   = i_valid && !i_restart;
        last_c     = accept_c && (slot_q == 2'd3);
        payloads_c = {i_block[DATA_WIDTH-1:0], pay_q[2], pay_q[1], pay_q[0]};
        headers_c  = {i_block[DATA_WIDTH+1:DATA_WIDTH], hdr_q[2], hdr_q[1], hdr_q[0]};
    end

    baser_257b_compress #(
        .DATA_WIDTH (DATA_WIDTH),
        .TC_WIDTH   (TC_WIDTH)
    ) u_compress (
        .payloads   (payloads_c),
        .headers    (headers_c),
        .tc_coded_c (tc_c),
        .tc_err_c   (err_c)
    );

    // Slot counter and storage of blk0..blk2; restart discards the partial group
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            slot_q <= 2'd0;
            for (int i = 0; i < int'(NSTORE); i++) begin
                pay_q[i] <= '0;
                hdr_q[i] <= '0;
            end
        end else if (i_restart) begin
            slot_q <= 2'd0;
            for (int i = 0; i < int'(NSTORE); i++) begin
                pay_q[i] <= '0;
                hdr_q[i] <= '0;
            end
        end else if (accept_c) begin
            slot_q <= slot_q + 2'd1;
            for (int i = 0; i < int'(NSTORE); i++) begin
                if (slot_q == 2'(i)) begin
                    pay_q[i] <= i_block[DATA_WIDTH-1:0];
                    hdr_q[i] <= i_block[DATA_WIDTH+1:DATA_WIDTH];
                end
            end
        end
    end

    // Output word and error are captured only on a group's final block and held otherwise
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_tc_coded <= '0;
            o_tc_err   <= 1'b0;
        end else begin
            o_valid <= last_c;
            if (last_c) begin
                o_tc_coded <= tc_c;
                o_tc_err   <= err_c;
            end
        end
    end

`ifdef BASER_257B_GEN_STATS_EN
    // Running statistics, updated together with the word they describe
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_block_count     <= '0;
            o_data_count      <= '0;
            o_ctrl_count      <= '0;
            o_inv_block_count <= '0;
        end else if (last_c) begin
            o_block_count <= o_block_count + CNT_W'(1);
            if (tc_c[0]) begin
                o_data_count <= o_data_count + CNT_W'(1);
            end else begin
                o_ctrl_count <= o_ctrl_count + CNT_W'(1);
            end
            if (err_c) begin
                o_inv_block_count <= o_inv_block_count + CNT_W'(1);
            end
        end
    end
`else
    assign o_block_count     = '0;
    assign o_data_count      = '0;
    assign o_ctrl_count      = '0;
    assign o_inv_block_count = '0;
`endif

endmodule

// File: doc/baser_257b_generator.md
BASER_257B_GENERATOR -- requirements
Module: baser_257b_generator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: payload width of one 66b block.
REQ-002 SHALL have parameter TC_WIDTH, default 4*DATA_WIDTH+1 = 257: transcoded block width.
REQ-003 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_valid, input, 1: i_block holds a 66b block this cycle.
REQ-006 SHALL have port i_block, input, 66: [65:64] sync header (2'b01 data, 2'b10 control, others invalid), [63:0] payload, with control block type field = payload[7:0].
REQ-007 SHALL have port i_restart, input, 1: synchronous discard of a partially gathered group.
REQ-008 SHALL have port o_valid, output, 1: o_tc_coded valid, one-cycle pulse per group.
REQ-009 SHALL have port o_tc_coded, output, TC_WIDTH: 257b transcoded block.
REQ-010 SHALL have port o_tc_err, output, 1: the current o_tc_coded group contained an invalid sync header.
REQ-011 SHALL have ports o_block_count, o_data_count, o_ctrl_count, o_inv_block_count, output, 32 each: running statistics.

Function
REQ-012 SHALL gather four accepted blocks (i_valid=1) in arrival order as blk0..blk3, using a 2-bit slot counter 0..3.
REQ-013 SHALL leave slot and storage unchanged on cycles with i_valid=0; gaps of any length SHALL be tolerated.
REQ-014 SHALL assert o_valid exactly on the cycle after blk3 is accepted, i.e. 1-cycle latency, registered outputs.
REQ-015 SHALL, on that same accept cycle, wrap the slot to 0, so a block arriving on the o_valid cycle becomes blk0 of the next group with no bubble.
REQ-016 SHALL, when all four headers are 2'b01, output o_tc_coded[0]=1 and o_tc_coded[256:1]={blk3,blk2,blk1,blk0} payloads.
REQ-017 SHALL otherwise output o_tc_coded[0]=0 and o_tc_coded[4:1] as a per-block flag, bit i+1 set iff blk i header is 2'b01.
REQ-018 SHALL, in the REQ-017 case, fill o_tc_coded[256:5] with the four payloads in order blk0 first, with payload[7:4] of the first non-data block removed (252 bits).
REQ-019 SHALL treat an invalid header (2'b00/2'b11) as a non-data block for REQ-017/018 and assert o_tc_err with o_valid.
REQ-020 SHALL hold o_tc_coded and o_tc_err stable between o_valid pulses.
REQ-021 SHALL, on i_restart=1, set slot to 0 and discard stored blocks; i_block on that cycle SHALL be ignored; a simultaneous pending o_valid SHALL still be emitted.
REQ-022 SHALL, on each o_valid, increment o_block_count, and increment o_data_count if REQ-016 applied, otherwise o_ctrl_count; o_inv_block_count SHALL increment once per group with o_tc_err.
REQ-023 SHALL let all counters wrap modulo 2^32 without saturation.

Reset
REQ-024 SHALL, on i_rst, clear slot, storage, o_valid, o_tc_coded, o_tc_err and all counters to 0 immediately.
REQ-025 SHALL discard a partial group when reset is asserted mid-gather; the first block after deassertion SHALL be blk0.

Configuration
REQ-026 SHALL compile the REQ-022 statistics counters only when macro BASER_257B_GEN_STATS_EN is defined.
REQ-027 SHALL, without BASER_257B_GEN_STATS_EN, tie the four count outputs to constant 0; transcoding SHALL be unchanged.

Structure
REQ-028 SHALL take sync header constants (data 2'b01, control 2'b10), the 257b width constant and the block-type nibble position from shared package baser_pkg.
REQ-029 SHALL place the REQ-016..019 combinational compression in sub-module baser_257b_compress, four payloads and headers in, 257b word and error out.

Verification
REQ-030 SHALL verify four data blocks with payloads 64'h0..03 -> o_valid one cycle after the 4th, o_tc_coded[0]=1, o_data_count=1.
REQ-031 SHALL verify blocks data, control type 8'h1E, data, data -> o_tc_coded[4:1]=4'b1101, blk1 upper type nibble removed, o_ctrl_count=1.
REQ-032 SHALL verify a header of 2'b11 in blk2 -> o_tc_err=1, o_tc_coded[3]=0, o_inv_block_count=1.
REQ-033 SHALL verify three blocks, 5 idle cycles, then one block -> a single o_valid; back-to-back groups -> o_valid every 4 cycles.
REQ-034 SHALL verify i_rst or i_restart after two blocks, then four new blocks -> output contains only the new blocks.
REQ-035 SHALL verify a build without BASER_257B_GEN_STATS_EN -> counters 0, o_tc_coded identical to the REQ-030 result.
